// File: rtl/traffic_controller_mealy_pkg.sv
// Shared types and constants for the two-road Mealy traffic controller:
// FSM state encoding, lamp codes and request masks.
package traffic_pkg;

    typedef enum logic [1:0] {
        MAIN_GREEN  = 2'd0,
        MAIN_YELLOW = 2'd1,
        SIDE_GREEN  = 2'd2,
        SIDE_YELLOW = 2'd3
    } state_e;

    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b10;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_SIDE = 2'b01;
    localparam logic [1:0] REQ_PED  = 2'b10;

    function automatic logic [3:0] packLamps(input logic [1:0] mainLamp, input logic [1:0] sideLamp);
        return {mainLamp, sideLamp};
    endfunction

endpackage

// File: rtl/traffic_controller_mealy_if.sv
// Sensor/lamp bundle between the request sources and the controller.
// The master side drives tick and requests; the slave (controller) drives lamps.
interface traffic_controller_mealy_if;
    logic       en;
    logic [1:0] in;
    logic [3:0] o;

    modport master (output en, output in, input o);
    modport slave  (input en, input in, output o);
endinterface

// File: rtl/traffic_controller_mealy_timer.sv
// Saturating phase timer: counts enabled cycles up to limit_i and holds there;
// done_o flags that the current phase has reached its terminal count.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [TW-1:0] limit_i,
    output logic          done_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != limit_i)) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == limit_i);

endmodule

// File: rtl/traffic_controller_mealy.sv
// Main/side traffic-light Mealy FSM: main rests on green, a request runs one
// yellow / side-green / yellow cycle, with early-yellow and gap-out decided combinationally.
module traffic_controller_mealy
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 4,
    parameter int YELLOW_TIME = 2,
    parameter int SIDE_MAX    = 6,
    parameter int TW          = 3
) (
    input  logic                       clk,
    input  logic                       res_n,
    traffic_controller_mealy_if.slave  bus
);

    localparam logic [TW-1:0] GREEN_LIM  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] YELLOW_LIM = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] SIDE_LIM   = TW'(SIDE_MAX - 1);

    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] limit;
    logic          timerDone;
    logic          req;
    logic          leaveGreen;
    logic          leaveSide;

    assign req        = |(bus.in & (REQ_SIDE | REQ_PED));
    assign leaveGreen = bus.en && req && timerDone;
    assign leaveSide  = bus.en && ((bus.in == REQ_NONE) || timerDone);

    always_comb begin
        case (state_q)
            MAIN_GREEN: limit = GREEN_LIM;
            SIDE_GREEN: limit = SIDE_LIM;
            default:    limit = YELLOW_LIM;
        endcase
    end

    // Timer restarts whenever the FSM is about to change phase.
    phase_timer #(.TW(TW)) u_timer (
        .clk     (clk),
        .res_n   (res_n),
        .clear_i (state_d != state_q),
        .en_i    (bus.en),
        .limit_i (limit),
        .done_o  (timerDone)
    );

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= MAIN_GREEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GREEN:  if (leaveGreen)             state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (bus.en && timerDone)    state_d = SIDE_GREEN;
            SIDE_GREEN:  if (leaveSide)              state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (bus.en && timerDone)    state_d = MAIN_GREEN;
            default:                                 state_d = MAIN_GREEN;
        endcase
    end

    // Mealy yellow terms are suppressed during reset so lamps follow the state alone.
    always_comb begin
        bus.o = packLamps(LAMP_GRN, LAMP_RED);
        case (state_q)
            MAIN_GREEN:  bus.o = (res_n && leaveGreen) ? packLamps(LAMP_YEL, LAMP_RED)
                                                       : packLamps(LAMP_GRN, LAMP_RED);
            MAIN_YELLOW: bus.o = packLamps(LAMP_YEL, LAMP_RED);
            SIDE_GREEN:  bus.o = (res_n && leaveSide)  ? packLamps(LAMP_RED, LAMP_YEL)
                                                       : packLamps(LAMP_RED, LAMP_GRN);
            SIDE_YELLOW: bus.o = packLamps(LAMP_RED, LAMP_YEL);
            default:     bus.o = packLamps(LAMP_GRN, LAMP_RED);
        endcase
    end

endmodule

// File: tb/tb_traffic_controller_mealy.sv
// Bench for traffic_controller_mealy: directed scenarios plus random traffic,
// each cycle's lamps compared against a phase/elapsed-time reference model.
module tb_traffic_controller_mealy;

    localparam int MIN_GREEN   = 4;
    localparam int YELLOW_TIME = 2;
    localparam int SIDE_MAX    = 6;
    localparam int TW          = 3;

    logic clk = 1'b0;
    logic res_n;
    int   checkCount = 0;
    int   failCount  = 0;
    int   cycleNum   = 0;

    // Reference model: which of the four phases we are in and cycles spent in it.
    int   phase      = 0;
    int   elapsed    = 0;
    bit   modelValid = 0;
    int   phaseLen [4] = '{MIN_GREEN, YELLOW_TIME, SIDE_MAX, YELLOW_TIME};

    traffic_controller_mealy_if bus ();

    traffic_controller_mealy #(
        .MIN_GREEN   (MIN_GREEN),
        .YELLOW_TIME (YELLOW_TIME),
        .SIDE_MAX    (SIDE_MAX),
        .TW          (TW)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic bit willAdvance(input logic [1:0] req);
        bit lastCycle;
        lastCycle = (elapsed == phaseLen[phase] - 1);
        case (phase)
            0:       return (req != 2'b00) && lastCycle;
            2:       return (req == 2'b00) || lastCycle;
            default: return lastCycle;
        endcase
    endfunction

    function automatic logic [3:0] modelOut(input logic r, input logic e, input logic [1:0] req);
        logic [1:0] mainLamp;
        logic [1:0] sideLamp;
        mainLamp = (phase == 0) ? 2'b10 : (phase == 1) ? 2'b01 : 2'b00;
        sideLamp = (phase == 2) ? 2'b10 : (phase == 3) ? 2'b01 : 2'b00;
        if (r && e && willAdvance(req)) begin
            if (phase == 0) mainLamp = 2'b01;
            if (phase == 2) sideLamp = 2'b01;
        end
        return {mainLamp, sideLamp};
    endfunction

    task automatic modelStep(input logic r, input logic e, input logic [1:0] req);
        if (!r) begin
            phase      = 0;
            elapsed    = 0;
            modelValid = 1;
        end else if (e) begin
            if (willAdvance(req)) begin
                phase   = (phase + 1) % 4;
                elapsed = 0;
            end else if (elapsed < phaseLen[phase] - 1) begin
                elapsed++;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] req);
        logic [3:0] exp;
        res_n  = r;
        bus.en = e;
        bus.in = req;
        @(negedge clk);
        exp = modelOut(r, e, req);
        if (modelValid) begin
            checkOutput($sformatf("lamps@%0d", cycleNum), bus.o, exp);
        end
        checkOutput($sformatf("noConflict@%0d", cycleNum),
                    {3'b000, (bus.o[3:2] == 2'b00) || (bus.o[1:0] == 2'b00)}, 4'b0001);
        @(posedge clk);
        modelStep(r, e, req);
        cycleNum++;
        #1;
    endtask

    task automatic runCycles(input int n, input logic r, input logic e, input logic [1:0] req);
        for (int k = 0; k < n; k++) applyStimulus(r, e, req);
    endtask

    task automatic doReset();
        runCycles(2, 1'b0, 1'b1, 2'b00);
    endtask

    initial begin
        res_n  = 1'b0;
        bus.en = 1'b0;
        bus.in = 2'b00;

        doReset();
        runCycles(20, 1'b1, 1'b1, 2'b00);

        // Full side cycle with a held vehicle request, then a gap-out.
        doReset();
        runCycles(3 + 1 + 2 + 6 + 2, 1'b1, 1'b1, 2'b01);
        runCycles(4 + 2 + 2, 1'b1, 1'b1, 2'b01);
        runCycles(4, 1'b1, 1'b1, 2'b00);

        doReset();
        runCycles(10, 1'b1, 1'b1, 2'b10);
        doReset();
        runCycles(10, 1'b1, 1'b1, 2'b11);

        // Freeze mid-yellow, then freeze at an expired main-green with a request.
        doReset();
        runCycles(5, 1'b1, 1'b1, 2'b01);
        runCycles(5, 1'b1, 1'b0, 2'b01);
        runCycles(4, 1'b1, 1'b1, 2'b01);
        doReset();
        runCycles(6, 1'b1, 1'b1, 2'b00);
        runCycles(3, 1'b1, 1'b0, 2'b01);
        runCycles(2, 1'b1, 1'b1, 2'b01);

        doReset();
        runCycles(8, 1'b1, 1'b1, 2'b01);
        runCycles(1, 1'b0, 1'b1, 2'b01);
        runCycles(5, 1'b1, 1'b1, 2'b01);

        for (int k = 0; k < 1500; k++) begin
            applyStimulus(($urandom % 60) != 0, ($urandom % 4) != 0,
                          (($urandom % 3) == 0) ? 2'b00 : 2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
